led_seq_engine: RTL

- Parametrised successor to the throttle + sequencer pair on the LED board.
- Divides CLK_50 into a step tick selectable over NUM_RATES rates, with freq pushbuttons.
- Walks a pattern ROM at {seq_num, step} and drives LEDR; seq pushbuttons select the sequence.
- Adds playback modes (loop, ping-pong, one-shot, freeze), generalises LED count, step count and sequence count, and exports status for the seven-segment display block.

---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/pb_edge.sv | 32 +++
 rtl/led_seq_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and default parameter values for the LED sequencer.
//   mode_e : playback mode as driven on the 2-bit mode input
//   dir_e  : ping-pong walk direction
//   Def*   : default values for the led_seq_engine parameters
package led_seq_pkg;

    localparam int unsigned DefNumLeds = 10;
    localparam int unsigned DefSeqW    = 6;
    localparam int unsigned DefStepW   = 4;
    localparam int unsigned DefRateW   = 3;
    localparam int unsigned DefBaseDiv = 50000;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_FREEZE   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

endpackage

// File: rtl/pb_edge.sv
// pb_edge: two-flop synchroniser followed by a rising-edge detector for one
// (already debounced) pushbutton.
//   i_clk   : clock
//   i_reset : synchronous, active-high reset; clears the pulse register
//   i_pb    : asynchronous button level, active-high
//   o_pulse : one-cycle pulse per rising edge of i_pb
module pb_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pb,
    output logic o_pulse
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_pulse;

    // The synchroniser and the previous-level flop keep tracking the pin while
    // reset is held, so a button held through reset produces no edge afterwards.
    always_ff @(posedge i_clk) begin
        r_sync <= {r_sync[0], i_pb};
        r_prev <= r_sync[1];
        if (i_reset) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= r_sync[1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/led_seq_engine.sv
// led_seq_engine: rate divider, pattern-step FSM and LED output stage.
//   CLK_50, reset            : clock, synchronous active-high reset
//   pb_freq_up/pb_freq_dn    : raise/lower the step rate (async levels)
//   pb_seq_up/pb_seq_dn      : next/previous sequence (async levels)
//   mode                     : 0 loop, 1 ping-pong, 2 one-shot, 3 freeze
//   brightness               : PWM duty, only used when LED_SEQ_PWM_EN is defined
//   rom_addr / rom_data      : {seq_num, step} to a 1-cycle-latency pattern ROM
//   LEDR                     : LED drive
//   seq_num, freq_num        : current sequence and rate index (0 slowest)
//   step_tick                : one-cycle pulse per step
//   done                     : one-shot sequence finished
// Build option: define LED_SEQ_PWM_EN to gate LEDR with a 16-level PWM.
module led_seq_engine
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DefNumLeds,
    parameter int unsigned SEQ_W    = DefSeqW,
    parameter int unsigned STEP_W   = DefStepW,
    parameter int unsigned RATE_W   = DefRateW,
    parameter int unsigned BASE_DIV = DefBaseDiv
) (
    input  logic                    CLK_50,
    input  logic                    reset,
    input  logic                    pb_freq_up,
    input  logic                    pb_freq_dn,
    input  logic                    pb_seq_up,
    input  logic                    pb_seq_dn,
    input  logic [1:0]              mode,
    input  logic [3:0]              brightness,
    output logic [SEQ_W+STEP_W-1:0] rom_addr,
    input  logic [NUM_LEDS-1:0]     rom_data,
    output logic [NUM_LEDS-1:0]     LEDR,
    output logic [SEQ_W-1:0]        seq_num,
    output logic [RATE_W-1:0]       freq_num,
    output logic                    step_tick,
    output logic                    done
);

    localparam int unsigned NumRates  = 1 << RATE_W;
    localparam int unsigned MaxPeriod = BASE_DIV << (NumRates - 1);
    localparam int unsigned CntW      = $clog2(MaxPeriod);

    localparam logic [STEP_W-1:0] StepMax = '1;
    localparam logic [STEP_W-1:0] StepOne = STEP_W'(1);
    localparam logic [RATE_W-1:0] RateMax = '1;

    // Button pulses
    logic w_freq_up, w_freq_dn, w_seq_up, w_seq_dn;

    pb_edge u_pb_freq_up (.i_clk(CLK_50), .i_reset(reset), .i_pb(pb_freq_up), .o_pulse(w_freq_up));
    pb_edge u_pb_freq_dn (.i_clk(CLK_50), .i_reset(reset), .i_pb(pb_freq_dn), .o_pulse(w_freq_dn));
    pb_edge u_pb_seq_up  (.i_clk(CLK_50), .i_reset(reset), .i_pb(pb_seq_up),  .o_pulse(w_seq_up));
    pb_edge u_pb_seq_dn  (.i_clk(CLK_50), .i_reset(reset), .i_pb(pb_seq_dn),  .o_pulse(w_seq_dn));

    // State
    logic [RATE_W-1:0]   r_freq, w_freq_d;
    logic [CntW-1:0]     r_div, w_div_d;
    logic [SEQ_W-1:0]    r_seq, w_seq_d;
    logic [STEP_W-1:0]   r_step, w_step_d;
    dir_e                r_dir, w_dir_d;
    logic                r_done, w_done_d;
    logic [NUM_LEDS-1:0] r_led, w_led_d;

    mode_e w_mode;
    assign w_mode = mode_e'(mode);

    // Divider: period doubles for each step down from the fastest rate. The
    // period is formed one bit wider so the slowest period itself is
    // representable; its low CntW bits minus one give the terminal count.
    logic [RATE_W-1:0] w_shift;
    logic [CntW:0]     w_period;
    logic [CntW:0]     w_last;
    logic              w_tick;

    assign w_shift  = RateMax - r_freq;
    assign w_period = (CntW + 1)'(BASE_DIV) << w_shift;
    assign w_last   = w_period - (CntW + 1)'(1);
    assign w_tick   = (r_div == w_last[CntW-1:0]);

    always_comb begin
        w_freq_d = r_freq;
        if (w_freq_up && !w_freq_dn && (r_freq != RateMax)) begin
            w_freq_d = r_freq + 1'b1;
        end else if (w_freq_dn && !w_freq_up && (r_freq != '0)) begin
            w_freq_d = r_freq - 1'b1;
        end
    end

    // A real rate change restarts the period from zero.
    always_comb begin
        w_div_d = r_div + 1'b1;
        if ((w_freq_d != r_freq) || w_tick) begin
            w_div_d = '0;
        end
    end

    // Step FSM: a sequence change outranks a coincident tick.
    always_comb begin
        w_seq_d  = r_seq;
        w_step_d = r_step;
        w_dir_d  = r_dir;
        w_done_d = r_done;
        if (w_seq_up ^ w_seq_dn) begin
            w_seq_d  = w_seq_up ? r_seq + 1'b1 : r_seq - 1'b1;
            w_step_d = '0;
            w_dir_d  = DIR_FWD;
            w_done_d = 1'b0;
        end else if (w_tick) begin
            case (w_mode)
                MODE_LOOP: begin
                    w_step_d = r_step + 1'b1;
                end
                MODE_PINGPONG: begin
                    if (r_dir == DIR_FWD) begin
                        if (r_step == StepMax) begin
                            w_dir_d  = DIR_REV;
                            w_step_d = StepMax - 1'b1;
                        end else begin
                            w_step_d = r_step + 1'b1;
                        end
                    end else begin
                        if (r_step == '0) begin
                            w_dir_d  = DIR_FWD;
                            w_step_d = StepOne;
                        end else begin
                            w_step_d = r_step - 1'b1;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (r_step != StepMax) begin
                        w_step_d = r_step + 1'b1;
                    end
                    // done rises on the tick that lands on (or sits at) the last step
                    if (r_step >= StepMax - 1'b1) begin
                        w_done_d = 1'b1;
                    end
                end
                default: begin
                    // freeze: hold
                end
            endcase
        end
        if (w_mode != MODE_ONESHOT) begin
            w_done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_freq <= '0;
            r_div  <= '0;
            r_seq  <= '0;
            r_step <= '0;
            r_dir  <= DIR_FWD;
            r_done <= 1'b0;
            r_led  <= '0;
        end else begin
            r_freq <= w_freq_d;
            r_div  <= w_div_d;
            r_seq  <= w_seq_d;
            r_step <= w_step_d;
            r_dir  <= w_dir_d;
            r_done <= w_done_d;
            r_led  <= w_led_d;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    assign w_led_d = rom_data & {NUM_LEDS{r_pwm < brightness}};
`else
    logic w_unused_brightness;
    assign w_unused_brightness = ^brightness;
    assign w_led_d = rom_data;
`endif

    assign rom_addr  = {r_seq, r_step};
    assign LEDR      = r_led;
    assign seq_num   = r_seq;
    assign freq_num  = r_freq;
    assign step_tick = w_tick;
    assign done      = r_done;

endmodule
